// File: rtl/jk_cmd_seq.sv
// jk_cmd_seq: paced command sequencer for a downstream JK flip-flop.
// Commands ({j,k}) are queued in a small FIFO. One command is issued to j/k on
// each cycle where step is high. q_model shadows the expected downstream q.
// Optional macro JK_FB_CHECK_EN enables a sticky compare of q_fb against
// q_model. Without the macro, err is tied low and q_fb is ignored.
//
// Handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both high. cmd_ready is a register that depends only on
// internal state, never on cmd_valid. Upstream may present or change cmd
// freely while cmd_valid is low.
module jk_cmd_seq #(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    input  logic [1:0]             cmd,
    output logic                   cmd_ready,
    input  logic                   step,
    output logic                   j,
    output logic                   k,
    input  logic                   q_fb,
    output logic                   q_model,
    output logic [$clog2(DEPTH):0] count,
    output logic                   err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [1:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;
    logic [CW-1:0] count_next;
    logic [1:0]    jk_next;
    logic          chk_en;

    // Next-state, FIFO handshake decode and the next j/k drive.
    always_comb begin
        state_next = state;
        push       = 1'b0;
        pop        = 1'b0;
        jk_next    = 2'b00;
        count_next = count;
        case (state)
            INIT: begin
                // Force the downstream flop to a known 0 before real traffic.
                jk_next    = 2'b01;
                state_next = RUN;
            end
            RUN: begin
                push = cmd_valid && cmd_ready;
                pop  = step && (count != '0);
                if (pop) begin
                    jk_next = mem[rd_ptr];
                end
                case ({push, pop})
                    2'b10:   count_next = count + CW'(1);
                    2'b01:   count_next = count - CW'(1);
                    default: count_next = count;
                endcase
            end
            default: state_next = INIT;
        endcase
    end

    // State register, FIFO pointers/occupancy and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= INIT;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            j         <= 1'b0;
            k         <= 1'b0;
            cmd_ready <= 1'b0;
        end else begin
            state     <= state_next;
            count     <= count_next;
            j         <= jk_next[1];
            k         <= jk_next[0];
            // Registered ready: the post-edge value of (count < DEPTH) in RUN.
            cmd_ready <= (state_next == RUN) && (count_next < DEPTH_C);
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    // FIFO storage; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= cmd;
        end
    end

    // Shadow of the downstream JK flop, driven by the j/k currently presented.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_model <= 1'b0;
        end else begin
            case ({j, k})
                2'b01:   q_model <= 1'b0;
                2'b10:   q_model <= 1'b1;
                2'b11:   q_model <= ~q_model;
                default: q_model <= q_model;
            endcase
        end
    end

    // Check-enable rises on the edge that applies the INIT reset command.
    always_ff @(posedge clk) begin
        if (rst) begin
            chk_en <= 1'b0;
        end else if (state == RUN) begin
            chk_en <= 1'b1;
        end
    end

`ifdef JK_FB_CHECK_EN
    // Sticky mismatch between returned q and the shadow model.
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (chk_en && (q_fb != q_model)) begin
            err <= 1'b1;
        end
    end
`else
    logic unused_fb;
    assign unused_fb = q_fb ^ chk_en;
    assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_jk_cmd_seq.sv
// tb_jk_cmd_seq: directed plus random stimulus for jk_cmd_seq (DEPTH=4) with a
// downstream JK flop on j/k. A queue-based reference model predicts j/k, count,
// cmd_ready, q_model and err after every edge.
module tb_jk_cmd_seq;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd = 2'b00;
  logic       step = 1'b0;
  logic       cmd_ready;
  logic       j;
  logic       k;
  logic       q_fb;
  logic       q_model;
  logic [2:0] count;
  logic       err;
  logic       q_ds;
  logic       fb_force = 1'b0;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [1:0] exp_q[$];
  logic       m_run = 1'b0;
  logic       m_ready = 1'b0;
  logic       m_q = 1'b0;
  logic       m_chk = 1'b0;
  logic       m_err = 1'b0;
  logic [1:0] m_jk = 2'b00;

  // Clock and reset block: 10-unit period.
  always #5 clk = ~clk;

  jk_cmd_seq #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd       (cmd),
    .cmd_ready (cmd_ready),
    .step      (step),
    .j         (j),
    .k         (k),
    .q_fb      (q_fb),
    .q_model   (q_model),
    .count     (count),
    .err       (err)
  );

  // Downstream JK flop.
  always @(posedge clk) begin
    case ({j, k})
      2'b01:   q_ds <= 1'b0;
      2'b10:   q_ds <= 1'b1;
      2'b11:   q_ds <= ~q_ds;
      default: q_ds <= q_ds;
    endcase
  end

  assign q_fb = fb_force ? 1'b1 : q_ds;

  task automatic chk(input string tag, input string what, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, what, obs, exp);
    end
  endtask

  // One clock: sample pre-edge handshake, advance model, compare after edge.
  task automatic tick(input string tag);
    logic       push;
    logic       pop;
    logic       fb;
    logic       q_old;
    logic [1:0] jk_old;
    push   = cmd_valid && m_ready;
    pop    = m_run && step && (exp_q.size() > 0);
    fb     = q_fb;
    q_old  = m_q;
    jk_old = m_jk;
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      m_run   = 1'b0;
      m_ready = 1'b0;
      m_q     = 1'b0;
      m_chk   = 1'b0;
      m_err   = 1'b0;
      m_jk    = 2'b00;
    end else begin
      case (jk_old)
        2'b01:   m_q = 1'b0;
        2'b10:   m_q = 1'b1;
        2'b11:   m_q = ~q_old;
        default: m_q = q_old;
      endcase
`ifdef JK_FB_CHECK_EN
      if (m_chk && (fb !== q_old)) m_err = 1'b1;
`endif
      if (m_run) m_chk = 1'b1;
      if (!m_run) begin
        m_jk  = 2'b01;
        m_run = 1'b1;
      end else begin
        m_jk = pop ? exp_q.pop_front() : 2'b00;
        if (push) exp_q.push_back(cmd);
      end
      m_ready = (exp_q.size() < DEPTH);
    end
    #1;
    chk(tag, "jk", {30'd0, j, k}, {30'd0, m_jk});
    chk(tag, "count", {29'd0, count}, exp_q.size());
    chk(tag, "cmd_ready", {31'd0, cmd_ready}, {31'd0, m_ready});
    chk(tag, "q_model", {31'd0, q_model}, {31'd0, m_q});
    chk(tag, "err", {31'd0, err}, {31'd0, m_err});
    if (m_chk && !fb_force) chk(tag, "q_downstream", {31'd0, q_ds}, {31'd0, q_model});
  endtask

  // Driver: offer one command for one cycle.
  task automatic drive(input string tag, input logic v, input logic [1:0] c, input logic s);
    cmd_valid = v;
    cmd       = c;
    step      = s;
    tick(tag);
  endtask

  logic [1:0] stream_cmds [4] = '{2'b10, 2'b11, 2'b11, 2'b01};
  logic [1:0] fill_cmds   [5] = '{2'b10, 2'b01, 2'b11, 2'b10, 2'b11};

  initial begin
    // Reset held two cycles, then INIT.
    rst = 1'b1;
    tick("reset");
    tick("reset");
    rst = 1'b0;
    tick("init");
    tick("post_init");

    // Back-to-back streaming with step high.
    for (int i = 0; i < 4; i++) drive("stream", 1'b1, stream_cmds[i], 1'b1);
    for (int i = 0; i < 3; i++) drive("stream_drain", 1'b0, 2'b00, 1'b1);

    // Fill while stalled: fifth command must be refused.
    for (int i = 0; i < 5; i++) drive("fill", 1'b1, fill_cmds[i], 1'b0);
    for (int i = 0; i < 5; i++) drive("fill_drain", 1'b0, 2'b00, 1'b1);

    // Simultaneous push/pop at count=2, running pointers past wrap.
    drive("simul_pre", 1'b1, 2'b10, 1'b0);
    drive("simul_pre", 1'b1, 2'b11, 1'b0);
    for (int i = 0; i < 10; i++) drive("simul", 1'b1, 2'($urandom_range(0, 3)), 1'b1);
    for (int i = 0; i < 3; i++) drive("simul_drain", 1'b0, 2'b00, 1'b1);

    // Random traffic.
    for (int i = 0; i < 60; i++)
      drive("random", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    for (int i = 0; i < 5; i++) drive("random_drain", 1'b0, 2'b00, 1'b1);

    // Feedback mismatch right after a fresh init (q_model=0).
    rst = 1'b1;
    drive("mm_reset", 1'b0, 2'b00, 1'b0);
    rst = 1'b0;
    tick("mm_init");
    tick("mm_post_init");
    fb_force = 1'b1;
    tick("mm_force");
    fb_force = 1'b0;
    tick("mm_hold");
    tick("mm_hold");

    // Reset mid-operation with three queued commands.
    for (int i = 0; i < 3; i++) drive("mid_fill", 1'b1, 2'b10, 1'b0);
    rst = 1'b1;
    drive("mid_reset", 1'b0, 2'b00, 1'b1);
    rst = 1'b0;
    tick("mid_init");
    for (int i = 0; i < 5; i++) drive("mid_after", 1'b0, 2'b00, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jk_cmd_seq.md
JK_CMD_SEQ -- requirements
Module: jk_cmd_seq

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning command FIFO depth (power of 2, 2..16).
REQ-002 SHALL have ports as follows:
clk  in  1  sole clock; all state changes on rising edge.
rst  in  1  synchronous active-high reset.
cmd_valid  in  1  upstream command valid.
cmd  in  2  {j,k} command: 00 hold, 01 reset, 10 set, 11 toggle.
cmd_ready  out  1  command accepted at edge when cmd_valid&cmd_ready.
step  in  1  pacing strobe; FIFO head issued only on edges with step=1.
j  out  1  registered J drive to downstream JK flop.
k  out  1  registered K drive to downstream JK flop.
q_fb  in  1  q returned from downstream JK flop.
q_model  out  1  shadow of expected downstream q.
count  out  $clog2(DEPTH)+1  FIFO occupancy.
err  out  1  sticky feedback-mismatch flag.

Function
REQ-003 SHALL implement FSM with states INIT and RUN; INIT lasts exactly one cycle after reset release, then RUN permanently until next rst.
REQ-004 SHALL, on the first edge with rst=0 (state INIT), drive j=0,k=1 for one cycle regardless of step and FIFO, and enter RUN.
REQ-005 SHALL hold cmd_ready=0 in INIT; in RUN cmd_ready = (count < DEPTH), computed from registered count only.
REQ-006 SHALL, in RUN, on an edge with step=1 and count>0 (pre-edge value), pop FIFO head into {j,k}; otherwise drive j=k=0.
REQ-007 SHALL give latency: command accepted at edge N into empty FIFO with step=1 at N+1 appears on j/k after edge N+1 for exactly one cycle.
REQ-008 SHALL preserve command order; no command dropped or duplicated.
REQ-009 SHALL, on simultaneous push and pop, leave count unchanged; push when full is impossible (cmd_ready=0 even if pop occurs that edge).
REQ-010 SHALL wrap FIFO read/write pointers modulo DEPTH.
REQ-011 SHALL update q_model at every edge from the current j/k: 00 keep, 01 -> 0, 10 -> 1, 11 -> invert.
REQ-012 SHALL set internal check-enable at the edge that applies the INIT command to q_model; cleared only by rst.
REQ-013 SHALL keep j, k, q_model, cmd_ready, count, err as registered outputs (no combinational input-to-output path).

Reset
REQ-014 SHALL, while rst=1: state=INIT, FIFO empty, count=0, j=0, k=0, q_model=0, err=0, check-enable=0, cmd_ready=0.
REQ-015 SHALL discard all queued commands on rst asserted mid-operation and replay INIT on release.

Configuration
REQ-016 SHALL honour macro JK_FB_CHECK_EN: when defined, with check-enable=1, q_fb != q_model at an edge sets err=1 until rst.
REQ-017 SHALL, without JK_FB_CHECK_EN, tie err=0 and ignore q_fb; all other behaviour identical.

Verification (DEPTH=4, downstream JK flop instantiated on j/k/clk)
REQ-018 Reset/init: rst=1 two cycles, release -> j/k=01 for one cycle after first edge, then 00; cmd_ready 0 then 1; q_model=0; downstream q=0.
REQ-019 Streaming: step=1, push 10,11,11,01 back-to-back -> j/k 10,11,11,01 on consecutive cycles; q_model 1,0,1,0; q_fb matches, err=0.
REQ-020 Fill/stall: step=0, offer 5 commands -> 4 accepted, count=4, cmd_ready=0 after 4th; step=1 -> drained in 4 cycles in order, count 3,2,1,0.
REQ-021 Simultaneous: count=2, step=1, cmd_valid=1 -> count stays 2 while both persist; wrap past pointer DEPTH-1 -> order preserved.
REQ-022 Mismatch (JK_FB_CHECK_EN): after init, force q_fb=1 with q_model=0 -> err=1 next edge, stays 1 after release of force until rst.
REQ-023 Reset mid-operation: count=3, rst=1 one cycle -> count=0, j=k=0, err=0; release -> INIT 01 reissued; prior queued commands never appear.
